// File: rtl/mem_sp_pipe.sv
// Single-port RAM with valid/ready requests, byte-strobed writes, a configurable
// read pipeline and one-cycle error strobes for out-of-range addresses.
module mem_sp_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  output logic                    ready,
  input  logic                    wr_rd,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    err
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0] pipe_err_q, pipe_err_d;
  logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data_d [RD_LATENCY];
  logic                  wr_err_q, wr_err_d;

  logic                accept, wr_acc, rd_acc, in_range;
  logic [IdxWidth-1:0] idx;

  // Ready is gated by rst directly so it drops in the very cycle reset is applied.
  assign ready    = ~rst & (state_q == StIdle);
  assign accept   = valid & ready;
  assign wr_acc   = accept & wr_rd;
  assign rd_acc   = accept & ~wr_rd;
  assign in_range = (32'(addr) < DEPTH);
  assign idx      = addr[IdxWidth-1:0];

  assign rvalid = pipe_vld_q[RD_LATENCY-1];
  assign rdata  = pipe_data_q[RD_LATENCY-1];
  assign err    = wr_err_q | pipe_err_q[RD_LATENCY-1];

  // Busy-state sequencing: stay out of IDLE until the response cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rd_acc && (RD_LATENCY > 1)) begin
          state_d = StRdWait;
          cnt_d   = 2'(RD_LATENCY - 2);
        end
      end
      StRdWait: begin
        if (cnt_q == 2'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte-strobed array update; out-of-range writes only raise the error strobe.
  always_comb begin
    mem_d    = mem_q;
    wr_err_d = wr_acc & ~in_range;
    if (wr_acc && in_range) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (wstrb[b]) mem_d[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // Read pipeline; data stages only load behind a valid so rdata holds when idle.
  always_comb begin
    pipe_vld_d  = pipe_vld_q;
    pipe_err_d  = pipe_err_q;
    pipe_data_d = pipe_data_q;
    pipe_vld_d[0] = rd_acc;
    pipe_err_d[0] = rd_acc & ~in_range;
    if (rd_acc) pipe_data_d[0] = in_range ? mem_q[idx] : '0;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
      if (pipe_vld_q[i-1]) pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  // State registers; reset clears the array and discards in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      wr_err_q   <= 1'b0;
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_data_q[i] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_err_q    <= wr_err_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_err_q  <= pipe_err_d;
      pipe_data_q <= pipe_data_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_mem_sp_pipe.sv
// Scoreboard bench for mem_sp_pipe: the driver predicts responses from a word-array
// model at each accepted request; a negedge monitor pops and compares them.
module tb_mem_sp_pipe;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned L     = 2;
  localparam int unsigned NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic          wr_rd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wstrb = '0;
  logic          ready, rvalid, err;
  logic [DW-1:0] rdata;

  mem_sp_pipe #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW),
    .RD_LATENCY(L)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .ready (ready),
    .wr_rd (wr_rd),
    .addr  (addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .rdata (rdata),
    .rvalid(rvalid),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          rd_q[$];
  int            werr_q[$];
  logic [DW-1:0] model [DEPTH];
  int            cyc = 0;
  int            busy_until = 0;
  int            checks = 0;
  int            failures = 0;
  int            n_acc = 0;
  int            n_hs = 0;
  logic          rst_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour at an accepted request (called at the acceptance edge).
  task automatic accept_req(input logic w, input int a, input logic [DW-1:0] d,
                            input logic [NB-1:0] s);
    exp_t e;
    n_acc++;
    if (w) begin
      if (a < int'(DEPTH)) begin
        for (int b = 0; b < int'(NB); b++) if (s[b]) model[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        werr_q.push_back(cyc + 1);
      end
    end else begin
      e.data = (a < int'(DEPTH)) ? model[a] : '0;
      e.err  = (a >= int'(DEPTH));
      e.cyc  = cyc + int'(L);
      rd_q.push_back(e);
      busy_until = cyc + int'(L);
    end
  endtask

  // Present a request and hold it until accepted; leaves valid high on return.
  task automatic req(input logic w, input int a, input logic [DW-1:0] d,
                     input logic [NB-1:0] s);
    bit   done = 0;
    logic rdy;
    valid = 1'b1;
    wr_rd = w;
    addr  = AW'(a);
    wdata = d;
    wstrb = s;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      rdy = ready;
      @(posedge clk);
      if (rdy) begin
        done = 1;
        accept_req(w, a, d, s);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout: addr %0d never accepted", a);
    end
    #1;
  endtask

  task automatic stop();
    valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    valid = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the queued expectations every cycle.
  exp_t m_e;
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_reset", ready, 0);
      if (rst_at_edge) begin
        chk("rvalid_in_reset", rvalid, 0);
        chk("err_in_reset", err, 0);
        chk("rdata_in_reset", rdata, 0);
      end
      rd_q.delete();
      werr_q.delete();
      busy_until = 0;
    end else begin
      chk("ready", ready, 64'(cyc >= busy_until));
      if (valid && ready) n_hs++;
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        m_e = rd_q.pop_front();
        checks++;
        failures++;
        $display("FAIL rvalid_missing: got none expected response due cycle %0d", m_e.cyc);
      end
      if (rvalid) begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rvalid_unexpected: got rvalid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          m_e = rd_q.pop_front();
          chk("rvalid_timing", 64'(cyc), 64'(m_e.cyc));
          chk("rdata", rdata, m_e.data);
          chk("rd_err", err, m_e.err);
        end
      end
      if (werr_q.size() > 0 && werr_q[0] == cyc) begin
        chk("wr_err", err, 1);
        void'(werr_q.pop_front());
      end else if (err && !rvalid) begin
        checks++;
        failures++;
        $display("FAIL err_unexpected: got err=1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Freshly reset memory reads all zero.
    for (int a = 0; a < int'(DEPTH); a++) req(1'b0, a, '0, '0);
    stop();

    // Partial-strobe merge.
    req(1'b1, 5, 32'hDEADBEEF, 4'b1111);
    req(1'b1, 5, 32'h00001122, 4'b0011);
    req(1'b0, 5, '0, '0);
    stop();
    idle(3);

    // Read-after-write with no bubble.
    req(1'b1, 3, 32'hA5A5A5A5, 4'b1111);
    req(1'b0, 3, '0, '0);
    stop();
    idle(2);

    // Out-of-range accesses and an empty strobe.
    req(1'b1, 200, 32'h12345678, 4'b1111);
    req(1'b0, 8, '0, '0);
    req(1'b0, 16, '0, '0);
    req(1'b1, 7, 32'hFFFFFFFF, 4'b0000);
    req(1'b0, 7, '0, '0);
    req(1'b0, 255, '0, '0);
    stop();
    idle(2);

    // Continuous traffic: strict alternation, then random mix.
    for (int i = 0; i < 300; i++) begin
      logic w;
      w = (i < 60) ? logic'(i % 2) : logic'($urandom_range(0, 1));
      req(w, int'($urandom_range(0, DEPTH + 3)), DW'($urandom), NB'($urandom_range(0, 15)));
    end
    stop();
    idle(L + 2);

    // Reset while a read is in flight: the response must be discarded.
    req(1'b1, 9, 32'hCAFEF00D, 4'b1111);
    req(1'b0, 9, '0, '0);
    do_reset(3);
    for (int a = 0; a < int'(DEPTH); a++) req(1'b0, a, '0, '0);
    stop();
    idle(L + 3);

    @(negedge clk);
    chk("queues_drained", 64'(rd_q.size() + werr_q.size()), 0);
    chk("handshake_count", 64'(n_hs), 64'(n_acc));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_sp_pipe.md
# mem_sp_pipe

Parametrised single-port RAM with valid/ready request handshake, byte-enable writes, configurable read latency and out-of-range error signalling. It is the next generation of the single-port `memory` block: it sits behind the same `mem_intf`-style request bus and keeps its port names. It adds width, depth and latency generality, byte strobes, a response-valid strobe and address checking.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- DEPTH, 16, number of words; legal range 2..256.
- ADDR_WIDTH, 8, address bus width; addresses in DEPTH..2^ADDR_WIDTH-1 are out of range.
- RD_LATENCY, 2, cycles from read acceptance to response; legal range 1..4.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- valid  in  1  request valid.
- ready  out  1  block can accept a request this cycle.
- wr_rd  in  1  1 = write, 0 = read.
- addr  in  ADDR_WIDTH  word address.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables for writes; bit i covers wdata[8i+7:8i].
- rdata  out  DATA_WIDTH  read data, meaningful only while rvalid = 1.
- rvalid  out  1  one-cycle read response strobe.
- err  out  1  one-cycle error strobe for an out-of-range access.

## Operation
- Transfer: a request is accepted on a rising edge where valid && ready. The master holds valid, wr_rd, addr, wdata and wstrb stable until the request is accepted. When ready = 0, valid is ignored.
- FSM states: IDLE and RD_WAIT.
  - IDLE: ready = 1.
  - RD_WAIT: ready = 0; a down-counter tracks the remaining latency.
- In-range write, accepted in IDLE: each byte with wstrb = 1 is written at the acceptance edge. Bytes with wstrb = 0 are unchanged. The FSM stays in IDLE, so back-to-back writes run at one per cycle. wstrb = 0 is legal: no memory change and no err.
- Out-of-range write: memory is unchanged; err = 1 for exactly one cycle.
- Read: the array is sampled at the acceptance edge and the data passes through an RD_LATENCY-stage pipeline.
  - RD_LATENCY = 1: the FSM stays in IDLE.
  - RD_LATENCY > 1: the FSM goes to RD_WAIT for RD_LATENCY-1 cycles, then returns to IDLE in the cycle that rvalid is asserted.
- Out-of-range read: rvalid asserts with normal timing, rdata = 0 and err = 1 in the same cycle.
- Reset: every memory word is cleared to 0, the pipeline is flushed and the FSM goes to IDLE. A read pending at reset never produces rvalid.

## Timing
- Reset values while rst = 1: ready = 0, rvalid = 0, err = 0, rdata = 0. ready = 1 in the first cycle after rst falls.
- Write accepted at edge N: the new data is visible to a read accepted at edge N+1 (read-after-write with no bubble).
- Write err: high during cycle N+1 only.
- Read accepted at edge N: rvalid = 1 and rdata are valid during the cycle after edge N+RD_LATENCY-1, i.e. RD_LATENCY cycles after the request cycle. rvalid is never high for two consecutive cycles from one request.
- ready stays low in the cycles between read acceptance and the response cycle. ready is high in the response cycle itself, so a new request can be accepted while the response is presented.
- Read throughput: with RD_LATENCY = 1, one read per cycle. Otherwise, one read per RD_LATENCY cycles.
- err and rvalid are pulses; the block has no backpressure on responses.
- rdata holds its last value when rvalid = 0; the bench must not check it then.
- rst asserted mid-read: the response is discarded and rvalid stays 0.

## Test plan
- Reset, then read every address 0..DEPTH-1: each read returns rdata = 0, rvalid = 1 exactly RD_LATENCY cycles after acceptance, err = 0.
- Write 0xDEADBEEF to addr 5 with wstrb = 4'b1111, then write 0x00001122 with wstrb = 4'b0011, then read addr 5: rdata = 0xDEAD1122.
- Write 0xA5A5A5A5 to addr 3 at edge N and read addr 3 at edge N+1 (RD_LATENCY = 2): ready is low for one cycle after the read, then rvalid = 1 with rdata = 0xA5A5A5A5.
- Write to addr 200 with DEPTH = 16: err pulses for one cycle and addr 200 mod 16 (addr 8) still reads 0. Read addr 16: rvalid = 1, rdata = 0, err = 1 in the same cycle.
- Hold valid high with alternating read/write traffic: the number of accepted requests equals the number of valid && ready edges, and no request is lost or duplicated.
- Assert rst one cycle after a read is accepted with RD_LATENCY = 3: rvalid never asserts, ready = 0 during reset, and all memory words read back 0 afterwards.
